// File: rtl/tqvp_htfab_pwm_meter_pkg.sv
// Shared register map and reset constants for the PWM generator / duty-cycle meter.
package tqvp_htfab_pwm_meter_pkg;

    localparam logic [3:0] ADDR_DUTY0  = 4'd0;
    localparam logic [3:0] ADDR_STEP   = 4'd4;
    localparam logic [3:0] ADDR_MODE   = 4'd6;
    localparam logic [3:0] ADDR_STATUS = 4'd7;
    localparam logic [3:0] ADDR_SRC0   = 4'd8;
    localparam logic [3:0] ADDR_MEAS0  = 4'd12;

    localparam logic [7:0] DUTY_RST    = 8'h80;

endpackage

// File: rtl/tqvp_htfab_duty_meter.sv
// One duty-cycle measurement channel: saturating high-time accumulator latched once per window.
module tqvp_htfab_duty_meter
    import tqvp_htfab_pwm_meter_pkg::*;
#(
    parameter int FRAC_BITS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] step,
    input  logic       sig,
    input  logic       wend,
    input  logic       src_wr,
    input  logic       ready_clr,
    output logic [7:0] meas,
    output logic       ready
);
    localparam int AW = 8 + FRAC_BITS;

    logic [AW-1:0] acc;
    logic [AW-1:0] acc_add;
    logic [AW:0]   acc_sum;
    logic          discard;

    assign acc_add = sig ? AW'(step) : '0;
    assign acc_sum = {1'b0, acc} + {1'b0, acc_add};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '0;
            meas    <= '0;
            ready   <= 1'b0;
            discard <= 1'b0;
        end else begin
            // Clear comes first so a coinciding window end can set the flag again.
            if (ready_clr)
                ready <= 1'b0;
            if (src_wr) begin
                acc     <= '0;
                discard <= 1'b1;
            end else if (wend) begin
                // The window-end cycle itself starts the next window.
                acc <= acc_add;
                if (discard) begin
                    discard <= 1'b0;
                end else begin
                    meas  <= acc[AW-1 -: 8];
                    ready <= 1'b1;
                end
            end else begin
                acc <= acc_sum[AW] ? '1 : acc_sum[AW-1:0];
            end
        end
    end

endmodule

// File: rtl/tqvp_htfab_pwm_meter.sv
// TinyQV peripheral: PWM / sigma-delta outputs and duty-cycle meters sharing one phase accumulator.
module tqvp_htfab_pwm_meter
    import tqvp_htfab_pwm_meter_pkg::*;
#(
    parameter int FRAC_BITS = 8,
    parameter int N_OUT     = 3,
    parameter int N_IN      = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);
    localparam int PW = 8 + FRAC_BITS;

    logic [PW-1:0]   phase;
    logic [PW-1:0]   phase_next;
    logic [7:0]      tbase;
    logic            tick;
    logic            t7_q;
    logic            wend;
    logic [7:0]      step;
    logic [7:0]      mode;
    logic [2:0]      o;
    logic [3:0][7:0] duty_rd;
    logic [3:0][2:0] src_rd;
    logic [3:0][7:0] meas_rd;
    logic [3:0]      ready_rd;

    assign phase_next = phase + PW'(step);
    assign tbase      = phase[PW-1 -: 8];
    assign tick       = phase_next[PW-1 -: 8] != tbase;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase <= '0;
            t7_q  <= 1'b0;
            wend  <= 1'b0;
            step  <= '0;
            mode  <= '0;
        end else begin
            phase <= phase_next;
            t7_q  <= tbase[7];
            wend  <= t7_q & ~tbase[7];
            if (data_write && address == ADDR_STEP)
                step <= data_in;
            if (data_write && address == ADDR_MODE)
                mode <= data_in;
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_out
        if (k < N_OUT) begin : g_on
            logic [7:0] duty;
            logic [7:0] sd;
            logic       sd_o;
            logic [8:0] sd_sum;

            assign sd_sum = {1'b0, sd} + {1'b0, duty};

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    duty <= DUTY_RST;
                    sd   <= '0;
                    sd_o <= 1'b0;
                end else begin
                    if (data_write && address == ADDR_DUTY0 + 4'(k))
                        duty <= data_in;
                    if (tick)
                        {sd_o, sd} <= sd_sum;
                end
            end

            assign o[k]       = (mode[k] ? sd_o : (tbase < duty)) ^ mode[4+k];
            assign duty_rd[k] = duty;
        end else begin : g_off
            assign o[k]       = 1'b0;
            assign duty_rd[k] = '0;
        end
    end
    assign duty_rd[3] = '0;

    for (genvar k = 0; k < 4; k++) begin : g_in
        if (k < N_IN) begin : g_on
            logic [2:0] src;
            logic       src_wr;
            logic       ready_clr;
            logic [7:0] meas;
            logic       ready;

            assign src_wr    = data_write && address == ADDR_SRC0 + 4'(k);
            assign ready_clr = data_write && address == ADDR_STATUS && data_in[k];

            always_ff @(posedge clk) begin
                if (!rst_n)
                    src <= 3'(k);
                else if (src_wr)
                    src <= data_in[2:0];
            end

            tqvp_htfab_duty_meter #(.FRAC_BITS(FRAC_BITS)) u_meter (
                .clk       (clk),
                .rst_n     (rst_n),
                .step      (step),
                .sig       (ui_in[src]),
                .wend      (wend),
                .src_wr    (src_wr),
                .ready_clr (ready_clr),
                .meas      (meas),
                .ready     (ready)
            );

            assign src_rd[k]   = src;
            assign meas_rd[k]  = meas;
            assign ready_rd[k] = ready;
        end else begin : g_off
            assign src_rd[k]   = '0;
            assign meas_rd[k]  = '0;
            assign ready_rd[k] = 1'b0;
        end
    end

    assign uo_out = {o, ~ui_in[4], o, ui_in[0]};

    always_comb begin
        data_out = '0;
        if (address[3:2] == ADDR_MEAS0[3:2])
            data_out = meas_rd[address[1:0]];
        else if (address[3:2] == ADDR_SRC0[3:2])
            data_out = {5'b0, src_rd[address[1:0]]};
        else if (address == ADDR_STEP)
            data_out = step;
        else if (address == ADDR_MODE)
            data_out = mode;
        else if (address == ADDR_STATUS)
            data_out = {4'b0, ready_rd};
        else if (address[3:2] == ADDR_DUTY0[3:2])
            data_out = duty_rd[address[1:0]];
    end

endmodule

// File: tb/tb_tqvp_htfab_pwm_meter.sv
// Directed bench for tqvp_htfab_pwm_meter with default parameters (FRAC_BITS=8, N_OUT=3, N_IN=2).
module tb_tqvp_htfab_pwm_meter;
    import tqvp_htfab_pwm_meter_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uo_out;
    logic [3:0] address = 4'd0;
    logic       data_write = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tqvp_htfab_pwm_meter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ui_in      (ui_in),
        .uo_out     (uo_out),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out)
    );

    task automatic step_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        address    = a;
        data_in    = d;
        data_write = 1'b1;
        @(posedge clk);
        #1;
        data_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        address = a;
        #1;
        d = data_out;
    endtask

    task automatic test_reset;
        logic [7:0] exp_t [16];
        logic [7:0] d;
        exp_t = '{8'h80, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        rst_n = 1'b0;
        ui_in = 8'h11;
        step_clk(2);
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), d);
            checks++;
            if (d !== exp_t[a]) begin
                errors++;
                $display("FAIL reset_reg[%0d]: got %02h expected %02h", a, d, exp_t[a]);
            end
            step_clk(1);
        end
        checks++;
        if (uo_out !== 8'hEF) begin
            errors++;
            $display("FAIL reset_uo_out: got %02h expected ef", uo_out);
        end
        wr(ADDR_MODE, 8'h70);
        checks++;
        if (uo_out !== 8'h01) begin
            errors++;
            $display("FAIL invert_all: got %02h expected 01", uo_out);
        end
        wr(ADDR_MODE, 8'h00);
    endtask

    task automatic test_pwm;
        logic [7:0] t;
        int hi1, hi2, hi3, mism, run, maxrun;
        hi1 = 0; hi2 = 0; hi3 = 0; mism = 0; run = 0; maxrun = 0;
        wr(ADDR_DUTY0, 8'h40);
        wr(ADDR_DUTY0 + 4'd1, 8'h00);
        checks++;
        if (uo_out[2] !== 1'b0 || uo_out[6] !== 1'b0) begin
            errors++;
            $display("FAIL duty_zero_next_cycle: got %b%b expected 00", uo_out[6], uo_out[2]);
        end
        wr(ADDR_STEP, 8'h80);
        for (int c = 0; c < 1024; c++) begin
            t = 8'(c / 2);
            if (uo_out[1] !== (t < 8'h40) || uo_out[5] !== (t < 8'h40) ||
                uo_out[3] !== (t < 8'h80))
                mism++;
            if (uo_out[1]) hi1++;
            if (uo_out[2]) hi2++;
            if (uo_out[3]) hi3++;
            if (uo_out[1]) begin
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            step_clk(1);
        end
        checks++;
        if (mism !== 0) begin
            errors++;
            $display("FAIL pwm_vs_time_model: got %0d mismatching cycles expected 0", mism);
        end
        checks++;
        if (hi1 !== 256) begin
            errors++;
            $display("FAIL pwm_duty40_high_count: got %0d expected 256", hi1);
        end
        checks++;
        if (maxrun !== 128) begin
            errors++;
            $display("FAIL pwm_duty40_run: got %0d expected 128", maxrun);
        end
        checks++;
        if (hi2 !== 0) begin
            errors++;
            $display("FAIL pwm_duty00_high_count: got %0d expected 0", hi2);
        end
        checks++;
        if (hi3 !== 512) begin
            errors++;
            $display("FAIL pwm_duty80_high_count: got %0d expected 512", hi3);
        end
    endtask

    task automatic test_sigma_delta;
        logic ex;
        int mism, first, hi;
        mism = 0; first = -1; hi = 0;
        rst_n = 1'b0;
        step_clk(1);
        rst_n = 1'b1;
        wr(ADDR_DUTY0, 8'h40);
        wr(ADDR_MODE, 8'h01);
        wr(ADDR_STEP, 8'h80);
        for (int c = 0; c < 256; c++) begin
            ex = (c >= 8) && ((c % 8) < 2);
            if (uo_out[1] !== ex || uo_out[5] !== ex) mism++;
            if (uo_out[1] === 1'b1 && first < 0) first = c;
            if (uo_out[1]) hi++;
            step_clk(1);
        end
        checks++;
        if (mism !== 0) begin
            errors++;
            $display("FAIL sd_pattern: got %0d mismatching cycles expected 0", mism);
        end
        checks++;
        if (first !== 8) begin
            errors++;
            $display("FAIL sd_first_pulse: got cycle %0d expected 8", first);
        end
        checks++;
        if (hi !== 62) begin
            errors++;
            $display("FAIL sd_high_count: got %0d expected 62", hi);
        end
        wr(ADDR_MODE, 8'h11);
        checks++;
        if (uo_out[1] !== 1'b0 || uo_out[5] !== 1'b0) begin
            errors++;
            $display("FAIL sd_inverted: got %b%b expected 00", uo_out[5], uo_out[1]);
        end
    endtask

    task automatic test_measure_w1c;
        logic [7:0] d;
        int r, s;
        r = -1;
        rst_n = 1'b0;
        ui_in = 8'h08;
        step_clk(1);
        rst_n = 1'b1;
        wr(ADDR_SRC0 + 4'd1, 8'h03);
        wr(ADDR_STEP, 8'h80);
        s = cyc;
        address = ADDR_STATUS;
        for (int i = 0; i < 1500 && r < 0; i++) begin
            step_clk(1);
            if (data_out[1] === 1'b1) r = cyc;
        end
        checks++;
        if (r < 0) begin
            errors++;
            $display("FAIL meas1_ready_timeout: got no ready expected ready within 1500 cycles");
        end else begin
            checks++;
            if ((r - s) < 1000 || (r - s) > 1100) begin
                errors++;
                $display("FAIL meas1_second_window: got ready after %0d cycles expected 1000..1100", r - s);
            end
            rd(ADDR_MEAS0 + 4'd1, d);
            checks++;
            if (d !== 8'hFF) begin
                errors++;
                $display("FAIL meas1_saturate: got %02h expected ff", d);
            end
            rd(ADDR_STATUS, d);
            checks++;
            if (d !== 8'h03) begin
                errors++;
                $display("FAIL status_after_wend: got %02h expected 03", d);
            end
            wr(ADDR_STATUS, 8'h02);
            rd(ADDR_STATUS, d);
            checks++;
            if (d !== 8'h01) begin
                errors++;
                $display("FAIL status_w1c: got %02h expected 01", d);
            end
            while (cyc < r + 511) step_clk(1);
            wr(ADDR_STATUS, 8'h02);
            rd(ADDR_STATUS, d);
            checks++;
            if (d !== 8'h03) begin
                errors++;
                $display("FAIL status_w1c_on_wend: got %02h expected 03", d);
            end
            wr(ADDR_STATUS, 8'h03);
            rd(ADDR_STATUS, d);
            checks++;
            if (d !== 8'h00) begin
                errors++;
                $display("FAIL status_w1c_both: got %02h expected 00", d);
            end
        end
    endtask

    task automatic test_half_duty;
        logic [7:0] d;
        rst_n = 1'b0;
        ui_in = 8'h00;
        step_clk(1);
        rst_n = 1'b1;
        wr(ADDR_STEP, 8'hFF);
        for (int i = 0; i < 600; i++) begin
            ui_in[0] = ((i % 16) < 8);
            step_clk(1);
        end
        rd(ADDR_MEAS0, d);
        checks++;
        if (d !== 8'h7F && d !== 8'h80) begin
            errors++;
            $display("FAIL meas0_half_duty: got %02h expected 7f or 80", d);
        end
        rd(ADDR_STATUS, d);
        checks++;
        if (d[0] !== 1'b1) begin
            errors++;
            $display("FAIL ready0_half_duty: got %b expected 1", d[0]);
        end
    endtask

    task automatic test_src_change;
        logic [7:0] d;
        int r;
        r = -1;
        rst_n = 1'b0;
        ui_in = 8'h01;
        step_clk(1);
        rst_n = 1'b1;
        wr(ADDR_STEP, 8'h80);
        address = ADDR_STATUS;
        for (int i = 0; i < 1000 && r < 0; i++) begin
            step_clk(1);
            if (data_out[0] === 1'b1) r = cyc;
        end
        checks++;
        if (r < 0) begin
            errors++;
            $display("FAIL meas0_ready_timeout: got no ready expected ready within 1000 cycles");
        end else begin
            rd(ADDR_MEAS0, d);
            checks++;
            if (d !== 8'hFF) begin
                errors++;
                $display("FAIL meas0_first_window: got %02h expected ff", d);
            end
            wr(ADDR_STATUS, 8'h01);
            while (cyc < r + 200) step_clk(1);
            wr(ADDR_SRC0, 8'h02);
            rd(ADDR_SRC0, d);
            checks++;
            if (d !== 8'h02) begin
                errors++;
                $display("FAIL src0_readback: got %02h expected 02", d);
            end
            while (cyc < r + 530) step_clk(1);
            rd(ADDR_MEAS0, d);
            checks++;
            if (d !== 8'hFF) begin
                errors++;
                $display("FAIL meas0_discarded_window: got %02h expected ff", d);
            end
            rd(ADDR_STATUS, d);
            checks++;
            if (d[0] !== 1'b0) begin
                errors++;
                $display("FAIL ready0_discarded_window: got %b expected 0", d[0]);
            end
            while (cyc < r + 1050) step_clk(1);
            rd(ADDR_MEAS0, d);
            checks++;
            if (d !== 8'h00) begin
                errors++;
                $display("FAIL meas0_new_source: got %02h expected 00", d);
            end
            rd(ADDR_STATUS, d);
            checks++;
            if (d[0] !== 1'b1) begin
                errors++;
                $display("FAIL ready0_new_source: got %b expected 1", d[0]);
            end
        end
    endtask

    task automatic test_reset_freeze;
        logic [3:0] addr_t [7];
        logic [7:0] exp_t [7];
        logic [7:0] d;
        int bad;
        addr_t = '{ADDR_DUTY0, ADDR_DUTY0 + 4'd1, ADDR_STEP, ADDR_MODE, ADDR_STATUS,
                   ADDR_SRC0, ADDR_SRC0 + 4'd1};
        exp_t  = '{8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        wr(ADDR_DUTY0, 8'h10);
        wr(ADDR_DUTY0 + 4'd1, 8'hC0);
        wr(ADDR_MODE, 8'h23);
        wr(ADDR_SRC0 + 4'd1, 8'h05);
        step_clk(100);
        ui_in = 8'h11;
        rst_n = 1'b0;
        step_clk(1);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            rd(addr_t[i], d);
            checks++;
            if (d !== exp_t[i]) begin
                errors++;
                $display("FAIL midreset_reg[%0d]: got %02h expected %02h", addr_t[i], d, exp_t[i]);
            end
        end
        checks++;
        if (uo_out !== 8'hEF) begin
            errors++;
            $display("FAIL midreset_uo_out: got %02h expected ef", uo_out);
        end
        wr(ADDR_DUTY0, 8'h40);
        wr(ADDR_STEP, 8'h80);
        ui_in = 8'h0F;
        step_clk(300);
        wr(ADDR_STEP, 8'h00);
        bad = 0;
        for (int i = 0; i < 1200; i++) begin
            if (uo_out !== 8'h11) bad++;
            step_clk(1);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL freeze_uo_out: got %0d cycles differing from 11 expected 0", bad);
        end
        rd(ADDR_STATUS, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL freeze_status: got %02h expected 00", d);
        end
        rd(ADDR_MEAS0, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL freeze_meas0: got %02h expected 00", d);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        step_clk(1);
        test_reset();
        test_pwm();
        test_sigma_delta();
        test_measure_w1c();
        test_half_duty();
        test_src_change();
        test_reset_freeze();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tqvp_htfab_pwm_meter.md
# tqvp_htfab_pwm_meter

Parametrised analog-tool peripheral for the TinyQV peripheral bus. It generates up to three PWM or first-order sigma-delta outputs from one shared fixed-point time base. It also measures the duty cycle of up to four selectable `ui_in` pins at the same time, one measurement per time-base window, with per-channel ready flags.

## Interface
Parameters:
- `FRAC_BITS`, default 8: fractional bits of the phase accumulator; the period is 256·2^FRAC_BITS/step cycles.
- `N_OUT`, default 3, range 1..3: number of generated outputs.
- `N_IN`, default 2, range 1..4: number of measurement channels.

Ports:
- `clk`  in  1: peripheral clock, normally 64 MHz.
- `rst_n`  in  1: synchronous, active-low reset.
- `ui_in`  in  8: input PMOD, already synchronised upstream.
- `uo_out`  out  8: output PMOD.
- `address`  in  4: register address.
- `data_write`  in  1: write strobe.
- `data_in`  in  8: write data, valid with `data_write`.
- `data_out`  out  8: read data for `address`, combinational from registers.

One clock; reset is synchronous and active-low.

## Operation
- **Phase accumulator:** `phase` is 8+FRAC_BITS bits and adds `step` every cycle, wrapping modulo.
  - `time = phase[top 8 bits]`.
  - `tick` = carry out of the fractional field (time advanced this cycle).
- **Window end (`wend`):** registered detection of `time[7]` going 1→0, asserted one cycle after the wrap.
- **Register map** (all readable; unimplemented addresses read 0):
  - 0..2: `duty[k]`, reset 0x80. Writes are ignored and reads return 0 for k ≥ N_OUT.
  - 4: `step`, reset 0x00.
  - 6: `mode`. Bit k selects sigma-delta for output k. Bit 4+k inverts output k. Reset 0x00.
  - 7: `status`. Bits [N_IN-1:0] are the ready flags. Writing 1 clears a flag (W1C).
  - 8..11: `src[k]`, bits [2:0] select `ui_in[src]`. Reset value k.
  - 12..15: `meas[k]`, read-only, reset 0x00.
- **PWM mode:** `o[k] = time < duty[k]`.
  - duty 0x00 gives constant low.
  - duty 0xFF gives high for 255/256 of the period.
- **Sigma-delta mode:** 8-bit `sd[k]`. On each `tick`, `{c, sd} = sd + duty[k]` and `o[k] = c` (registered). `sd` is cleared on reset.
- Inversion is applied last.
- **`uo_out`** = `{o[2:0], ~ui_in[4], o[2:0], ui_in[0]}`; bits for k ≥ N_OUT drive 0.
- **Measurement channel k:** `acc[k]` is 8+FRAC_BITS bits.
  - Adds `step` on each cycle where `ui_in[src[k]]` is high.
  - Saturates at all-ones; never wraps.
- **On `wend`:**
  - `meas[k] ← acc` integer byte.
  - `acc ← 0`.
  - `ready[k] ← 1`.
  - Exception: if `discard[k]` is set, update nothing and clear `discard[k]` instead.
- **Writing `src[k]`:** clears `acc[k]` and sets `discard[k]`, so the partial window is dropped.

## Timing
- A register write takes effect on the cycle after `data_write`. `uo_out` PWM bits reflect a new duty on that cycle.
- `step` changes mid-window do not restart the window.
- Simultaneous W1C and `wend` on the same channel: set wins.
- With `step = 0`:
  - `time` is frozen, so PWM outputs are constant.
  - Sigma-delta holds state.
  - No `wend` occurs; `meas` and `ready` are held.
- **After reset:** step=0 and time=0 with duty 0x80, so PWM bits read 1; ready=0, meas=0, discard=0.
- Reset asserted mid-window takes effect on the next edge and discards all partial windows.
- A full-high input for a whole window saturates `meas` to 0xFF.

## Structure
- Package `tqvp_htfab_pwm_meter_pkg` holds:
  - address constants (`ADDR_DUTY0`, `ADDR_STEP`, `ADDR_MODE`, `ADDR_STATUS`, `ADDR_SRC0`, `ADDR_MEAS0`);
  - reset constants (`DUTY_RST` = 0x80).
- Sub-module `tqvp_htfab_duty_meter` (one per input channel) holds `acc`, `meas`, `ready` and `discard`. It is instantiated N_IN times.
- The top level holds the phase accumulator, `wend` detection, output generators and register decode.

## Test plan
- **PWM:** step=0x80, FRAC_BITS=8, duty[0]=0x40 → window 512 cycles; uo_out[1] and uo_out[5] high for exactly 128 consecutive cycles per window.
- **Measurement saturation and W1C:** src[1]=3, ui_in[3] held high → after the second `wend`, meas[1]=0xFF and status bit 1 = 1. Write 0x02 to status → bit clears; a W1C issued on a `wend` cycle leaves the bit 1.
- **Half-duty input:** step=0xFF, ui_in[0] toggled with 50% duty at period 16 → meas[0] = 0x7F or 0x80.
- **Sigma-delta:** mode=0x01, duty[0]=0x40, step=0x80 → o[0] high for 2 cycles out of every 8, first pulse on the 4th tick.
- **Source change:** write src[0] mid-window → next `wend` leaves meas[0] and ready[0] unchanged; the following `wend` updates both.
- **Reset and freeze:** rst_n low for 1 cycle mid-window → all registers return to reset values and uo_out = {3'b111, ~ui_in[4], 3'b111, ui_in[0]}. step=0 then freezes all outputs and measurements.
